// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern transmitter and the benches that drive a
// pattern detector from it: tx state encoding and the default sync pattern.
package pattern_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        PAR  = 2'd3
    } tx_state_t;

    localparam int PREAMBLE_LEN = 5;

    localparam logic [PREAMBLE_LEN-1:0] PREAMBLE_DEFAULT = 5'b01001;

endpackage : pattern_pkg

// File: rtl/pattern_tx.sv
// Serial frame transmitter: preamble (MSB first), payload (MSB first), then an
// even-parity bit, one bit per clock on a registered line that idles high.
module pattern_tx
    import pattern_pkg::*;
#(
    parameter int                      DATA_W   = 8,
    parameter logic [PREAMBLE_LEN-1:0] PREAMBLE = PREAMBLE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = $clog2((PREAMBLE_LEN > DATA_W) ? PREAMBLE_LEN : DATA_W);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    tx_state_t               state, state_next;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic [DATA_W-1:0]       shreg, shreg_next;
    logic [PREAMBLE_LEN-1:0] pre_sr, pre_sr_next;
    logic                    par, par_next;
    logic                    ser_next;
    logic                    done_next;
    logic                    accept;

    assign in_ready = rst_n && (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            pre_sr     <= '0;
            par        <= 1'b0;
            ser_out    <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            shreg      <= shreg_next;
            pre_sr     <= pre_sr_next;
            par        <= par_next;
            ser_out    <= ser_next;
            frame_done <= done_next;
        end
    end

    // ser_next is the bit for the cycle after this edge, so each branch emits
    // the first bit of the phase it is entering.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        shreg_next  = shreg;
        pre_sr_next = pre_sr;
        par_next    = par;
        ser_next    = ser_out;
        done_next   = 1'b0;

        case (state)
            IDLE: begin
                ser_next = 1'b1;
                if (accept) begin
                    state_next  = PRE;
                    cnt_next    = '0;
                    shreg_next  = in_data;
                    par_next    = 1'b0;
                    ser_next    = PREAMBLE[PREAMBLE_LEN-1];
                    pre_sr_next = PREAMBLE << 1;
                end
            end

            PRE: begin
                if (cnt == PRE_LAST) begin
                    state_next = DATA;
                    cnt_next   = '0;
                    ser_next   = shreg[DATA_W-1];
                    par_next   = par ^ shreg[DATA_W-1];
                    shreg_next = shreg << 1;
                end else begin
                    cnt_next    = cnt + 1'b1;
                    ser_next    = pre_sr[PREAMBLE_LEN-1];
                    pre_sr_next = pre_sr << 1;
                end
            end

            DATA: begin
                if (cnt == DATA_LAST) begin
                    // par already holds the XOR of every payload bit sent.
                    state_next = PAR;
                    cnt_next   = '0;
                    ser_next   = par;
                end else begin
                    cnt_next   = cnt + 1'b1;
                    ser_next   = shreg[DATA_W-1];
                    par_next   = par ^ shreg[DATA_W-1];
                    shreg_next = shreg << 1;
                end
            end

            PAR: begin
                state_next = IDLE;
                ser_next   = 1'b1;
                done_next  = 1'b1;
            end

            default: begin
                state_next = IDLE;
                ser_next   = 1'b1;
            end
        endcase
    end

endmodule : pattern_tx
